uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 1023, meaning the maximum cycles in SEND waiting for tx_busy to rise.
REQ-003 The block SHALL have parameter GAP, default 2, meaning the minimum idle cycles between consecutive transmissions (1..15).
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ, where bit i is requester i asking to send one byte.
REQ-007 The block SHALL have port req_data, input, 8*NUM_REQ, where bits [8i+7:8i] are requester i's byte.
REQ-008 The block SHALL have port ack, output, NUM_REQ, a one-cycle pulse on bit i when requester i's byte is captured.
REQ-009 The block SHALL have port grant_id, output, clog2(NUM_REQ), the index of the requester currently being served.
REQ-010 The block SHALL have port tx_data, output, 9, the byte to the transmitter, formatted {stop bit 1'b1, byte[7:0]}.
REQ-011 The block SHALL have port tx_send, output, 1, the send request to the transmitter.
REQ-012 The block SHALL have port tx_busy, input, 1, the transmitter's busy flag.
REQ-013 The block SHALL have port idle, output, 1, high only in state IDLE.
REQ-014 The block SHALL have port timeout_err, output, 1, sticky, set on a SEND timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, SEND, WAIT_DONE and GAP_WAIT.
REQ-016 In IDLE with any req bit high, the block SHALL select one requester round-robin, starting the search at last_grant+1 and wrapping modulo NUM_REQ.
REQ-017 On selection the block SHALL latch req_data of the winner into tx_data, set grant_id, set last_grant to the winner, pulse ack for exactly that cycle and go to SEND.
REQ-018 In IDLE with req all zero, the block SHALL hold every output and last_grant unchanged.
REQ-019 In SEND, tx_send SHALL be 1; tx_busy=1 SHALL move to WAIT_DONE; otherwise the timeout counter SHALL increment.
REQ-020 If the counter reaches TIMEOUT in SEND, the block SHALL set timeout_err, drop tx_send and go to GAP_WAIT; the byte is dropped and not retried.
REQ-021 In WAIT_DONE, tx_send SHALL be 0; tx_busy=0 SHALL move to GAP_WAIT.
REQ-022 In GAP_WAIT, tx_send SHALL be 0 for exactly GAP cycles, after which the block SHALL return to IDLE.
REQ-023 tx_data and grant_id SHALL remain stable from capture until the next capture.
REQ-024 Requesters SHALL hold req and req_data until ack; a req dropped before ack SHALL NOT be granted.
REQ-025 req changes during SEND, WAIT_DONE or GAP_WAIT SHALL have no effect until IDLE.
REQ-026 tx_busy=1 observed in IDLE or GAP_WAIT SHALL be ignored.
REQ-027 Capture-to-tx_send latency SHALL be 1 cycle; tx_send SHALL never be high outside SEND.

Reset
REQ-028 When reset=0 at a clk edge, the block SHALL enter IDLE regardless of state, including mid-transmission.
REQ-029 Reset values SHALL be: ack=0, tx_send=0, tx_data=9'h100, grant_id=0, idle=1, timeout_err=0, counters=0, last_grant=NUM_REQ-1 so that requester 0 wins first.
REQ-030 The block SHALL NOT drive reset to the transmitter; the system reset controls it separately.

Structure
REQ-031 FSM state encodings, the STOP_BIT constant (1'b1) and the TX_FRAME_W constant (9) SHALL live in the shared package uart_pkg.
REQ-032 The round-robin picker SHALL be a combinational sub-module uart_rr_picker (inputs req and last_grant; outputs valid and index).
REQ-033 The timeout and gap counters SHALL share one counter register.

Verification
REQ-034 Bench SHALL cover: reset, then req=4'b0001, data0=8'hA5 -> ack=0001 one cycle, tx_data=9'h1A5, tx_send high the next cycle until tx_busy rises.
REQ-035 Bench SHALL cover: req=4'b1111 held, data i=8'h10+i -> grants in order 0,1,2,3,0, each separated by a busy cycle plus GAP idle cycles.
REQ-036 Bench SHALL cover: last_grant=2, req=4'b0101 -> grant 0 (wrap), then 2.
REQ-037 Bench SHALL cover: tx_busy held 0 with TIMEOUT=15 -> timeout_err=1 after 15 SEND cycles, tx_send=0, return to IDLE after GAP cycles.
REQ-038 Bench SHALL cover: reset=0 asserted in WAIT_DONE -> next cycle idle=1, tx_send=0, timeout_err=0, and the next req grants requester 0.
REQ-039 Bench SHALL cover: tx_busy pulses while IDLE with req=0 -> no state change, no ack.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and frame format.
package uart_pkg;

  localparam logic        STOP_BIT   = 1'b1;
  localparam int unsigned TX_FRAME_W = 9;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSend     = 2'd1,
    StWaitDone = 2'd2,
    StGapWait  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module uart_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last_grant,
  output logic               valid,
  output logic [IdxW-1:0]    index
);

  int unsigned        cand;
  logic [NUM_REQ-1:0] req_sh;

  always_comb begin
    valid  = 1'b0;
    index  = '0;
    cand   = 0;
    req_sh = '0;
    // Search order last_grant+1 .. last_grant+NUM_REQ, so last_grant itself is tried last.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand   = (32'(last_grant) + i) % NUM_REQ;
      req_sh = req >> cand;
      if (!valid && req_sh[0]) begin
        valid = 1'b1;
        index = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from NUM_REQ requesters to one UART transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned GAP     = 2,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [8*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic [IdxW-1:0]         grant_id,
  output logic [TX_FRAME_W-1:0]   tx_data,
  output logic                    tx_send,
  input  logic                    tx_busy,
  output logic                    idle,
  output logic                    timeout_err
);

  localparam int unsigned CntMax = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  arb_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [IdxW-1:0]       grant_id_q, grant_id_d;
  logic [TX_FRAME_W-1:0] tx_data_q, tx_data_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  pick_valid;
  logic [IdxW-1:0]       pick_idx;
  logic [8*NUM_REQ-1:0]  data_sh;
  logic [7:0]            win_byte;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  assign data_sh  = req_data >> {pick_idx, 3'b000};
  assign win_byte = data_sh[7:0];
  assign cnt_inc  = cnt_q + CntW'(1);

  // One counter serves both the SEND timeout and the GAP_WAIT spacing.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          tx_data_d    = {STOP_BIT, win_byte};
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          cnt_d        = '0;
          state_d      = StSend;
        end
      end
      StSend: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_inc == CntW'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = StGapWait;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = StGapWait;
        end
      end
      StGapWait: begin
        if (cnt_inc == CntW'(GAP)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_grant_q  <= IdxW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      tx_data_q     <= {STOP_BIT, 8'h00};
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Ack marks the capture cycle; gated by reset because no capture happens while it is held.
  always_comb begin
    ack = '0;
    if (reset && (state_q == StIdle) && pick_valid) begin
      ack = NUM_REQ'(1) << pick_idx;
    end
  end

  assign tx_send     = (state_q == StSend);
  assign idle        = (state_q == StIdle);
  assign grant_id    = grant_id_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_err_q;

endmodule
